// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, registered borrow.
// A start/done handshake lets a controller chain operations with no idle cycle in between.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  // Handshake: start is a one-cycle request honoured only in IDLE or DONE
  // (busy=0, or the DONE cycle); done is a one-cycle pulse and diff/borrow_out/ovf
  // are valid from that pulse until the next completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Full-subtractor cell on the current LSBs.
  logic cell_d;
  logic cell_bout;

  always_comb begin
    cell_d    = a_q[0] ^ b_q[0] ^ bin_q;
    cell_bout = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          res_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        res_d = {cell_d, res_q[WIDTH-1:1]};
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        bin_d = cell_bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // The bit being shifted in now is the result MSB; sign bits were
          // saved at capture because the operand registers have shifted away.
          diff_d   = {cell_d, res_q[WIDTH-1:1]};
          borrow_d = cell_bout;
          ovf_d    = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
          state_d  = DONE;
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          res_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign ovf        = ovf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: cycle-level reference of accept/complete timing and
// arithmetic results for an 8-bit instance, plus an exhaustive sweep of a 4-bit instance.
module tb_serial_subtractor;

  localparam int W  = 8;
  localparam int W4 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow_out, ovf;
  logic [W-1:0] diff;
  logic [1:0]   dbg_state;

  logic          start4 = 1'b0;
  logic [W4-1:0] a4 = '0;
  logic [W4-1:0] b4 = '0;
  logic          busy4, done4, borrow4, ovf4;
  logic [W4-1:0] diff4;
  logic [1:0]    dbg_state4;

  serial_subtractor #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out),
    .ovf(ovf), .dbg_state(dbg_state)
  );

  serial_subtractor #(.WIDTH(W4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4),
    .ovf(ovf4), .dbg_state(dbg_state4)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int free_at = 0;
  logic [W-1:0] exp_q[$];
  bit           exp_br_q[$];
  bit           exp_ov_q[$];
  int           acc_q[$];
  logic [W-1:0] held_diff = '0;
  bit           held_br = 1'b0;
  bit           held_ov = 1'b0;
  bit           exp_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views.
  function automatic void ref_sub(input int wd, input int unsigned x, input int unsigned y,
                                  output int unsigned d, output bit br, output bit ov);
    int unsigned m;
    int sx, sy, r;
    m  = 32'd1 << wd;
    d  = (x + m - y) % m;
    br = (x < y);
    sx = (x >= m / 2) ? int'(x) - int'(m) : int'(x);
    sy = (y >= m / 2) ? int'(y) - int'(m) : int'(y);
    r  = sx - sy;
    ov = (r >= int'(m / 2)) || (r < -int'(m / 2));
  endfunction

  task automatic model_clear();
    exp_q.delete();
    exp_br_q.delete();
    exp_ov_q.delete();
    acc_q.delete();
    held_diff = '0;
    held_br   = 1'b0;
    held_ov   = 1'b0;
    free_at   = 0;
  endtask

  // ---------------- driver: one clock of the 8-bit DUT with full output check ----------------
  task automatic tick(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
    int unsigned d;
    bit br, ov;
    start = s;
    a     = av;
    b     = bv;
    @(posedge clk);
    cyc++;
    exp_done = 1'b0;
    if (!rst_n) begin
      model_clear();
    end else begin
      if (acc_q.size() > 0 && acc_q[0] + W + 1 == cyc) begin
        exp_done = 1'b1;
        void'(acc_q.pop_front());
        void'(exp_q.pop_front());
        void'(exp_br_q.pop_front());
        void'(exp_ov_q.pop_front());
      end
      if (acc_q.size() > 0 && acc_q[0] + W == cyc) begin
        held_diff = exp_q[0];
        held_br   = exp_br_q[0];
        held_ov   = exp_ov_q[0];
      end
      if (s && cyc >= free_at) begin
        ref_sub(W, av, bv, d, br, ov);
        exp_q.push_back(d[W-1:0]);
        exp_br_q.push_back(br);
        exp_ov_q.push_back(ov);
        acc_q.push_back(cyc);
        free_at = cyc + W + 1;
      end
    end
    #1;
    chk("done", 32'(done), 32'(exp_done));
    chk("busy", 32'(busy), 32'(cyc < free_at));
    chk("diff", 32'(diff), 32'(held_diff));
    chk("borrow_out", 32'(borrow_out), 32'(held_br));
    chk("ovf", 32'(ovf), 32'(held_ov));
  endtask

  // Issue one operation from idle and wait (bounded) for its done pulse.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    bit seen;
    seen = 1'b0;
    tick(1'b1, av, bv);
    for (int n = 0; n < 2 * W && !seen; n++) begin
      tick(1'b0, W'($urandom), W'($urandom));
      seen = done;
    end
    chk("run_op_timeout", 32'(seen), 32'd1);
  endtask

  // One exhaustive-sweep operation on the 4-bit instance, latency included.
  task automatic run4(input logic [W4-1:0] x, input logic [W4-1:0] y);
    int unsigned d;
    bit br, ov;
    int lat;
    lat = -1;
    start4 = 1'b1;
    a4 = x;
    b4 = y;
    tick(1'b0, '0, '0);
    start4 = 1'b0;
    a4 = W4'($urandom);
    b4 = W4'($urandom);
    for (int n = 1; n <= 3 * W4 && lat < 0; n++) begin
      tick(1'b0, '0, '0);
      if (done4) lat = n;
    end
    ref_sub(W4, x, y, d, br, ov);
    chk("w4_latency", 32'(lat), 32'(W4 + 1));
    chk("w4_diff", 32'(diff4), 32'(d));
    chk("w4_borrow", 32'(borrow4), 32'(br));
    chk("w4_ovf", 32'(ovf4), 32'(ov));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    tick(1'b0, '0, '0);
    tick(1'b0, '0, '0);
    rst_n = 1'b1;
    tick(1'b0, '0, '0);

    // Basic and boundary operand pairs.
    run_op(8'd5, 8'd3);
    chk("t1_diff", 32'(diff), 32'h02);
    chk("t1_borrow", 32'(borrow_out), 32'd0);
    chk("t1_ovf", 32'(ovf), 32'd0);
    tick(1'b0, '0, '0);
    chk("t1_hold_diff", 32'(diff), 32'h02);
    run_op(8'd3, 8'd5);
    chk("t2_diff", 32'(diff), 32'hFE);
    chk("t2_borrow", 32'(borrow_out), 32'd1);
    chk("t2_ovf", 32'(ovf), 32'd0);
    run_op(8'hFF, 8'hFF);
    chk("t2b_diff", 32'(diff), 32'h00);
    chk("t2b_borrow", 32'(borrow_out), 32'd0);
    run_op(8'h80, 8'h01);
    chk("t3_diff", 32'(diff), 32'h7F);
    chk("t3_ovf", 32'(ovf), 32'd1);
    run_op(8'h7F, 8'hFF);
    chk("t3b_diff", 32'(diff), 32'h80);
    chk("t3b_ovf", 32'(ovf), 32'd1);
    run_op(8'h00, 8'hFF);
    run_op(8'h00, 8'h00);

    // start held high with operands changing every cycle: back-to-back ops.
    for (int i = 0; i < 4 * (W + 1); i++) tick(1'b1, W'($urandom), W'($urandom));
    for (int i = 0; i < W + 3; i++) tick(1'b0, W'($urandom), W'($urandom));

    // Asynchronous abort four cycles into an operation.
    tick(1'b1, 8'h37, 8'h12);
    for (int i = 0; i < 4; i++) tick(1'b0, '0, '0);
    rst_n = 1'b0;
    #2;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow_out), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    model_clear();
    tick(1'b0, '0, '0);
    tick(1'b0, '0, '0);
    rst_n = 1'b1;
    for (int i = 0; i < W + 3; i++) tick(1'b0, '0, '0);
    run_op(8'hA5, 8'h5A);
    chk("post_abort_diff", 32'(diff), 32'h4B);

    // Random sweep, enough accepted operations for well over 1000 pairs.
    for (int i = 0; i < 11000; i++)
      tick($urandom_range(0, 3) != 0, W'($urandom), W'($urandom));
    for (int i = 0; i < W + 3; i++) tick(1'b0, '0, '0);

    // Exhaustive 4-bit sweep.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        run4(W4'(x), W4'(y));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
